// File: rtl/tp_capture_if.sv
// Test-point capture bus: tester-side stimulus/readout signals bundled for the capture block.
// The tester/slow-control side is master; the capture block is slave.
interface tp_capture_if #(
    parameter int NPINS    = 4,
    parameter int TS_WIDTH = 12
);
    logic [NPINS-1:0]          tp_in;
    logic                      arm;
    logic                      clr;
    logic [NPINS-1:0]          trig_mask;
    logic                      rd_en;
    logic [TS_WIDTH+NPINS-1:0] rd_data;
    logic                      empty;
    logic                      full;
    logic                      ovfl;
    logic [1:0]                state;
    logic [NPINS-1:0]          tp_stable;

    modport master (
        output tp_in, arm, clr, trig_mask, rd_en,
        input  rd_data, empty, full, ovfl, state, tp_stable
    );

    modport slave (
        input  tp_in, arm, clr, trig_mask, rd_en,
        output rd_data, empty, full, ovfl, state, tp_stable
    );
endinterface

// File: rtl/tp_capture.sv
// Test-point receive logger: sync + glitch filter per pin, arm/trigger FSM,
// and a FWFT FIFO of {timestamp, pin levels} change records.
module tp_capture #(
    parameter int NPINS      = 4,
    parameter int TS_WIDTH   = 12,
    parameter int DEPTH_LOG2 = 4,
    parameter int FILT       = 3
) (
    input  logic          clk,
    input  logic          rst_b,
    tp_capture_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int RW    = TS_WIDTH + NPINS;
    localparam int CW    = (FILT > 1) ? $clog2(FILT) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(FILT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    logic [NPINS-1:0] stable_vec;
    logic [NPINS-1:0] flip_vec;

    // flip_reg marks an accepted level change; TP_STABLE toggles on the following edge,
    // so a level held FILT samples shows up FILT+2 edges after it is first sampled.
    generate
        for (genvar gi = 0; gi < NPINS; gi++) begin : g_pin
            logic          s1_reg, s2_reg, s3_reg;
            logic          flip_reg, stable_reg;
            logic [CW-1:0] cnt_reg;
            logic [CW-1:0] cnt_inc;

            assign cnt_inc = (cnt_reg == CNT_TOP) ? cnt_reg : cnt_reg + 1'b1;

            always_ff @(posedge clk or negedge rst_b) begin
                if (!rst_b) begin
                    s1_reg     <= 1'b0;
                    s2_reg     <= 1'b0;
                    s3_reg     <= 1'b0;
                    flip_reg   <= 1'b0;
                    stable_reg <= 1'b0;
                    cnt_reg    <= '0;
                end else begin
                    s1_reg <= bus.tp_in[gi];
                    s2_reg <= s1_reg;
                    s3_reg <= s2_reg;
                    if (flip_reg) begin
                        stable_reg <= ~stable_reg;
                        flip_reg   <= 1'b0;
                        cnt_reg    <= '0;
                    end else if (s2_reg == stable_reg) begin
                        cnt_reg  <= '0;
                        flip_reg <= 1'b0;
                    end else if (s2_reg != s3_reg) begin
                        cnt_reg  <= '0;
                        flip_reg <= (CNT_TOP == '0);
                    end else begin
                        cnt_reg  <= cnt_inc;
                        flip_reg <= (cnt_inc == CNT_TOP);
                    end
                end
            end

            assign stable_vec[gi] = stable_reg;
            assign flip_vec[gi]   = flip_reg;
        end
    endgenerate

    state_t              state_reg;
    logic [TS_WIDTH-1:0] ts_reg;
    logic                trig_hit;
    logic                any_ev;
    logic                wr_req;
    logic [RW-1:0]       wr_data;

    assign trig_hit = |(flip_vec & bus.trig_mask);
    assign any_ev   = |flip_vec;
    assign wr_data  = {ts_reg, stable_vec ^ flip_vec};

    always_comb begin
        wr_req = 1'b0;
        case (state_reg)
            ARMED:   wr_req = trig_hit;
            CAPTURE: wr_req = any_ev;
            default: wr_req = 1'b0;
        endcase
        if (bus.clr) wr_req = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_reg <= IDLE;
            ts_reg    <= '0;
        end else if (bus.clr) begin
            state_reg <= IDLE;
            ts_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    ts_reg <= '0;
                    if (bus.arm) state_reg <= ARMED;
                end
                ARMED: begin
                    ts_reg <= ts_reg + 1'b1;
                    if (trig_hit) state_reg <= CAPTURE;
                end
                CAPTURE: begin
                    // Window closes once the timestamp saturates; it is held there in DONE.
                    if (&ts_reg) state_reg <= DONE;
                    else         ts_reg    <= ts_reg + 1'b1;
                end
                default: state_reg <= DONE;
            endcase
        end
    end

    logic [RW-1:0]       mem [DEPTH];
    logic [DEPTH_LOG2:0] wr_ptr_reg, rd_ptr_reg;
    logic [DEPTH_LOG2:0] wr_ptr_next, rd_ptr_next;
    logic                empty_reg, full_reg, ovfl_reg;
    logic                empty_next, full_next;
    logic [RW-1:0]       rd_data_reg;
    logic                rd_do, wr_do;

    assign rd_do = bus.rd_en && !empty_reg && !bus.clr;
    assign wr_do = wr_req && (!full_reg || rd_do);

    always_comb begin
        wr_ptr_next = wr_ptr_reg + (DEPTH_LOG2 + 1)'(wr_do);
        rd_ptr_next = rd_ptr_reg + (DEPTH_LOG2 + 1)'(rd_do);
        if (bus.clr) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
        empty_next = (wr_ptr_next == rd_ptr_next);
        full_next  = (wr_ptr_next[DEPTH_LOG2] != rd_ptr_next[DEPTH_LOG2]) &&
                     (wr_ptr_next[DEPTH_LOG2-1:0] == rd_ptr_next[DEPTH_LOG2-1:0]);
    end

    always_ff @(posedge clk) begin
        if (wr_do) mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            empty_reg  <= 1'b1;
            full_reg   <= 1'b0;
            ovfl_reg   <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            empty_reg  <= empty_next;
            full_reg   <= full_next;
            if (bus.clr)
                ovfl_reg <= 1'b0;
            else if (wr_req && full_reg && !rd_do)
                ovfl_reg <= 1'b1;
        end
    end

    // Head register: bypass the write when it lands in the slot that becomes the head.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)
            rd_data_reg <= '0;
        else if (wr_do && (wr_ptr_reg == rd_ptr_next))
            rd_data_reg <= wr_data;
        else if (rd_do)
            rd_data_reg <= mem[rd_ptr_next[DEPTH_LOG2-1:0]];
    end

    assign bus.rd_data   = rd_data_reg;
    assign bus.empty     = empty_reg;
    assign bus.full      = full_reg;
    assign bus.ovfl      = ovfl_reg;
    assign bus.state     = state_reg;
    assign bus.tp_stable = stable_vec;
endmodule
